// File: rtl/control_register_bank.sv
// rtl/control_register_bank.sv - register bank with shadow prescalers and boundary-synchronous transfer
// Shadow PSCn copies to the active output only at a wrap edge or while the channel is disabled.
module control_register_bank #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                PSC_W    = 24,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(32'h4146_4701)
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              int_re_i,
  input  logic              int_we_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  input  logic [DATA_W-1:0] int_data_i,
  output logic [DATA_W-1:0] int_data_o,
  input  logic              wrap_1_i,
  input  logic              wrap_2_i,
  output logic              wc_en_1_o,
  output logic              wc_en_2_o,
  output logic [PSC_W-1:0]  wc_psc_1_o,
  output logic [PSC_W-1:0]  wc_psc_2_o
);

  localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PSC1 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_PSC2 = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(4);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam logic [PSC_W-1:0] PSC_MIN = PSC_W'(2);

  logic [1:0]            en_q, en_d;
  logic [1:0]            st_q, st_d;
  logic [1:0][PSC_W-1:0] shad_q, shad_d;
  logic [1:0][PSC_W-1:0] act_q, act_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [1:0]        wrap;
  logic [1:0]        upd_req;
  logic [1:0]        xfer;
  logic              addr_mapped;
  logic [PSC_W-1:0]  psc_wr_val;
  logic [DATA_W-1:0] rd_mux;

  assign wrap        = {wrap_2_i, wrap_1_i};
  assign addr_mapped = (int_addr_i <= A_STAT);
  assign psc_wr_val  = (int_data_i[PSC_W-1:0] < PSC_MIN) ? PSC_MIN : int_data_i[PSC_W-1:0];

  always_comb begin
    rd_mux = '0;
    case (int_addr_i)
      A_ID:    rd_mux = ID_VALUE;
      A_CTRL:  rd_mux = DATA_W'(en_q);
      A_PSC1:  rd_mux = DATA_W'(shad_q[0]);
      A_PSC2:  rd_mux = DATA_W'(shad_q[1]);
      A_STAT:  rd_mux = DATA_W'({err_q, 6'b0, st_q});
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    en_d    = en_q;
    st_d    = st_q;
    shad_d  = shad_q;
    act_d   = act_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    upd_req = '0;
    xfer    = '0;

    if (int_we_i && int_addr_i == A_CTRL) begin
      en_d = int_data_i[1:0];
    end

    // Transfer decisions use the EN value held before this edge, so a
    // combined EN+UPD write only takes effect on the FSM one edge later.
    for (int ch = 0; ch < 2; ch++) begin
      upd_req[ch] = int_we_i && (int_addr_i == A_CTRL) && int_data_i[8+ch];
      xfer[ch]    = (st_q[ch] == ST_PEND) && (wrap[ch] || !en_q[ch]);
      if (int_we_i && int_addr_i == ADDR_W'(2 + ch)) begin
        shad_d[ch] = psc_wr_val;
      end
      if (xfer[ch]) begin
        act_d[ch] = shad_q[ch];
      end
      if (upd_req[ch]) begin
        st_d[ch] = ST_PEND;
      end else if (xfer[ch]) begin
        st_d[ch] = ST_IDLE;
      end
    end

    if (int_we_i && int_addr_i == A_STAT && int_data_i[8]) begin
      err_d = 1'b0;
    end
    if ((int_we_i && (int_addr_i == A_ID || !addr_mapped)) || (int_re_i && !addr_mapped)) begin
      err_d = 1'b1;
    end

    if (int_re_i) begin
      rdata_d = rd_mux;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      en_q    <= '0;
      st_q    <= {ST_IDLE, ST_IDLE};
      shad_q  <= {PSC_MIN, PSC_MIN};
      act_q   <= {PSC_MIN, PSC_MIN};
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      st_q    <= st_d;
      shad_q  <= shad_d;
      act_q   <= act_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign int_data_o = rdata_q;
  assign wc_en_1_o  = en_q[0];
  assign wc_en_2_o  = en_q[1];
  assign wc_psc_1_o = act_q[0];
  assign wc_psc_2_o = act_q[1];

endmodule

// File: tb/tb_control_register_bank.sv
// tb/tb_control_register_bank.sv - self-checking bench for control_register_bank
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_control_register_bank;

  localparam logic [31:0] ID = 32'h4146_4701;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wrap1, wrap2;
  logic        en1, en2;
  logic [23:0] psc1, psc2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] e;
    string       nm;
  } vec_t;

  vec_t vecs[16];

  control_register_bank dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst),
    .int_re_i   (re),
    .int_we_i   (we),
    .int_addr_i (addr),
    .int_data_i (wdata),
    .int_data_o (rdata),
    .wrap_1_i   (wrap1),
    .wrap_2_i   (wrap2),
    .wc_en_1_o  (en1),
    .wc_en_2_o  (en2),
    .wc_psc_1_o (psc1),
    .wc_psc_2_o (psc2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] e, input string nm);
    re = 1'b1; addr = a;
    exp_q.push_back(e); name_q.push_back(nm);
    @(negedge clk);
    re = 1'b0;
    chk(name_q.pop_front(), rdata, exp_q.pop_front());
  endtask

  task automatic pulse_wrap(input int ch);
    if (ch == 1) wrap1 = 1'b1; else wrap2 = 1'b1;
    @(negedge clk);
    wrap1 = 1'b0; wrap2 = 1'b0;
  endtask

  task automatic write_with_wrap2(input logic [31:0] d);
    we = 1'b1; addr = 8'h01; wdata = d; wrap2 = 1'b1;
    @(negedge clk);
    we = 1'b0; wrap2 = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 32'h0,         ID,            "rd_id"};
    vecs[1]  = '{1'b0, 8'h01, 32'h0,         32'h0,         "rd_ctrl_rst"};
    vecs[2]  = '{1'b0, 8'h02, 32'h0,         32'h2,         "rd_psc1_rst"};
    vecs[3]  = '{1'b0, 8'h03, 32'h0,         32'h2,         "rd_psc2_rst"};
    vecs[4]  = '{1'b0, 8'h04, 32'h0,         32'h0,         "rd_stat_rst"};
    vecs[5]  = '{1'b1, 8'h02, 32'h0,         32'h0,         ""};
    vecs[6]  = '{1'b0, 8'h02, 32'h0,         32'h2,         "psc1_clamp0"};
    vecs[7]  = '{1'b1, 8'h02, 32'h1,         32'h0,         ""};
    vecs[8]  = '{1'b0, 8'h02, 32'h0,         32'h2,         "psc1_clamp1"};
    vecs[9]  = '{1'b1, 8'h03, 32'hFF12_3456, 32'h0,         ""};
    vecs[10] = '{1'b0, 8'h03, 32'h0,         32'h0012_3456, "psc2_upper_zero"};
    vecs[11] = '{1'b1, 8'h02, 32'h3,         32'h0,         ""};
    vecs[12] = '{1'b0, 8'h02, 32'h0,         32'h3,         "psc1_three"};
    vecs[13] = '{1'b1, 8'h01, 32'hFFFF_FC02, 32'h0,         ""};
    vecs[14] = '{1'b0, 8'h01, 32'h0,         32'h2,         "ctrl_en_bits_only"};
    vecs[15] = '{1'b1, 8'h01, 32'h0,         32'h0,         ""};

    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; wrap1 = 1'b0; wrap2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data_o", rdata, 32'h0);
    chk("rst_en", {30'b0, en2, en1}, 32'h0);
    chk("rst_psc1", {8'b0, psc1}, 32'h2);
    chk("rst_psc2", {8'b0, psc2}, 32'h2);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) do_write(vecs[i].a, vecs[i].d);
      else            do_read(vecs[i].a, vecs[i].e, vecs[i].nm);
    end
    chk("shadow_no_effect_psc1", {8'b0, psc1}, 32'h2);
    chk("shadow_no_effect_psc2", {8'b0, psc2}, 32'h2);

    // Disabled channel: PEND lasts exactly one cycle.
    do_write(8'h02, 32'd1000);
    do_write(8'h01, 32'h100);
    chk("dis_psc1_before", {8'b0, psc1}, 32'h2);
    do_read(8'h04, 32'h1, "dis_pend1_set");
    chk("dis_psc1_after", {8'b0, psc1}, 32'd1000);
    do_read(8'h04, 32'h0, "dis_pend1_clear");

    // Enabled channel waits for wrap.
    do_write(8'h01, 32'h2);
    do_write(8'h03, 32'd500);
    do_write(8'h01, 32'h202);
    repeat (20) @(negedge clk);
    chk("en2_out", {31'b0, en2}, 32'h1);
    chk("en_psc2_hold", {8'b0, psc2}, 32'h2);
    do_read(8'h04, 32'h2, "en_pend2_hold");
    pulse_wrap(2);
    chk("en_psc2_wrap", {8'b0, psc2}, 32'd500);
    do_read(8'h04, 32'h0, "en_pend2_clear");

    // Shadow rewrite during PEND, then UPD coincident with a transfer.
    do_write(8'h01, 32'h202);
    do_write(8'h03, 32'd700);
    pulse_wrap(2);
    chk("rewrite_psc2", {8'b0, psc2}, 32'd700);
    do_write(8'h03, 32'd800);
    do_write(8'h01, 32'h202);
    write_with_wrap2(32'h202);
    chk("coinc_xfer_psc2", {8'b0, psc2}, 32'd800);
    do_read(8'h04, 32'h2, "coinc_pend2_stays");
    pulse_wrap(2);
    do_write(8'h03, 32'd300);
    write_with_wrap2(32'h202);
    chk("idle_upd_wrap_no_xfer", {8'b0, psc2}, 32'd800);
    do_read(8'h04, 32'h2, "idle_upd_wrap_pend");
    pulse_wrap(2);
    chk("idle_upd_wrap_later", {8'b0, psc2}, 32'd300);
    do_read(8'h04, 32'h0, "idle_upd_wrap_clear");

    // Error flag and simultaneous read/write.
    do_read(8'h7F, 32'h0, "unmapped_rd");
    do_read(8'h04, 32'h100, "err_set_rd");
    do_write(8'h04, 32'h100);
    do_read(8'h04, 32'h0, "err_clear");
    do_write(8'h00, 32'h5);
    do_read(8'h00, ID, "id_not_written");
    do_read(8'h04, 32'h100, "err_set_wr_id");
    do_write(8'h04, 32'h100);
    re = 1'b1; we = 1'b1; addr = 8'h02; wdata = 32'd1234;
    exp_q.push_back(32'd1000); name_q.push_back("rw_same_old");
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    chk(name_q.pop_front(), rdata, exp_q.pop_front());
    do_read(8'h02, 32'd1234, "rw_same_new");

    // Reset while PEND1 discards the request.
    do_write(8'h01, 32'h1);
    do_write(8'h02, 32'd900);
    do_write(8'h01, 32'h101);
    do_read(8'h04, 32'h1, "pre_rst_pend1");
    rst = 1'b1;
    #1;
    chk("rst_async_psc1", {8'b0, psc1}, 32'h2);
    chk("rst_async_en1", {31'b0, en1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_data_o_again", rdata, 32'h0);
    do_read(8'h04, 32'h0, "rst_pend1_gone");
    pulse_wrap(1);
    repeat (3) @(negedge clk);
    chk("rst_no_late_xfer", {8'b0, psc1}, 32'h2);
    do_read(8'h02, 32'h2, "rst_shadow_psc1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
